// File: rtl/pipe_ex_2_pkg.sv
// Shared widths and ALU function codes for the pipe_ex_2 datapath.
package pipe_ex_2_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] MUL  = 4'd2;
  localparam logic [3:0] SELA = 4'd3;
  localparam logic [3:0] SELB = 4'd4;
  localparam logic [3:0] AND  = 4'd5;
  localparam logic [3:0] OR   = 4'd6;
  localparam logic [3:0] XOR  = 4'd7;
  localparam logic [3:0] NEGA = 4'd8;
  localparam logic [3:0] NEGB = 4'd9;
  localparam logic [3:0] SRA  = 4'd10;
  localparam logic [3:0] SLA  = 4'd11;

endpackage

// File: rtl/pipe_ex_2_alu.sv
// Combinational function unit for the execute stage; all results wrap modulo 2^DATA_W.
module pipe_alu
  import pipe_ex_2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        func,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (func)
      ADD:     result = a + b;
      SUB:     result = a - b;
      MUL:     result = a * b;
      SELA:    result = a;
      SELB:    result = b;
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      NEGA:    result = ~a;
      NEGB:    result = ~b;
      // SRA is a logical shift despite its name
      SRA:     result = a >> 1;
      SLA:     result = a << 1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipe_ex_2.sv
// Four-stage read / execute / write-back / store ALU pipeline with a 16-entry
// register bank and a result memory. No stalls, forwarding or hazard checks.
module pipe_ex_2
  import pipe_ex_2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] Z,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [3:0]        rd,
  input  logic [3:0]        func,
  input  logic [ADDR_W-1:0] addr
);

  logic [DATA_W-1:0] regbank [0:15];
  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];

  logic [DATA_W-1:0] a12, b12;
  logic [3:0]        rd12, func12;
  logic [ADDR_W-1:0] addr12;
  logic              v12;

  logic [DATA_W-1:0] res23;
  logic [3:0]        rd23;
  logic [ADDR_W-1:0] addr23;
  logic              v23;

  logic [ADDR_W-1:0] addr34;
  logic              v34;

  logic [DATA_W-1:0] alu_res;

  pipe_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a12),
    .b      (b12),
    .func   (func12),
    .result (alu_res)
  );

  // Register reads use the pre-edge bank contents, so a write-back landing on
  // the same edge is not visible to the instruction being sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a12    <= '0;
      b12    <= '0;
      rd12   <= '0;
      func12 <= '0;
      addr12 <= '0;
      v12    <= 1'b0;
      res23  <= '0;
      rd23   <= '0;
      addr23 <= '0;
      v23    <= 1'b0;
      Z      <= '0;
      addr34 <= '0;
      v34    <= 1'b0;
      for (int k = 0; k < 16; k++) regbank[k] <= DATA_W'(k);
    end else begin
      a12    <= regbank[rs1];
      b12    <= regbank[rs2];
      rd12   <= rd;
      func12 <= func;
      addr12 <= addr;
      v12    <= 1'b1;

      res23  <= alu_res;
      rd23   <= rd12;
      addr23 <= addr12;
      v23    <= v12;

      if (v23) regbank[rd23] <= res23;
      Z      <= res23;
      addr34 <= addr23;
      v34    <= v23;
    end
  end

  // Memory is never cleared; a reset edge only suppresses the store.
  always_ff @(posedge clk) begin
    if (rst_n && v34) mem[addr34] <= Z;
  end

endmodule

// File: tb/tb_pipe_ex_2.sv
// Self-checking bench for pipe_ex_2: vector table driven one per cycle, results
// scoreboarded through a queue, plus reset and hazard sequences.
module tb_pipe_ex_2;
  import pipe_ex_2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] Z;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;

  pipe_ex_2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Z     (Z),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd    (rd),
    .func  (func),
    .addr  (addr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    int          rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    logic [3:0]  rd;
    logic [7:0]  addr;
    bit          chk;
  } sb_t;

  vec_t vecs [17];
  sb_t  pipeq [$];
  sb_t  memq  [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Drive one instruction, advance one edge, then retire whatever is due.
  task automatic step(input logic [3:0] s1, input logic [3:0] s2, input int d,
                      input logic [3:0] f, input logic [7:0] a,
                      input logic [15:0] e, input bit chk);
    sb_t it;
    rs1 = s1; rs2 = s2; rd = 4'(d); func = f; addr = a;
    it.exp = e; it.rd = 4'(d); it.addr = a; it.chk = chk;
    pipeq.push_back(it);
    @(posedge clk); #1;
    if (memq.size() > 0) begin
      it = memq.pop_front();
      check($sformatf("mem[%0d]", it.addr), dut.mem[it.addr], it.exp);
    end
    if (pipeq.size() == 3) begin
      it = pipeq.pop_front();
      if (it.chk) begin
        check($sformatf("Z(rd=%0d,addr=%0d)", it.rd, it.addr), Z, it.exp);
        check($sformatf("regbank[%0d]", it.rd), dut.regbank[it.rd], it.exp);
        memq.push_back(it);
      end
    end
  endtask

  task automatic idle();
    step(4'd14, 4'd14, 14, SELA, 8'hFF, 16'd14, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    rs1 = 4'd14; rs2 = 4'd14; rd = 4'd14; func = SELA; addr = 8'hFF;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pipeq.delete();
    memq.delete();
    check("Z after reset", Z, 16'd0);
    for (int k = 0; k < 16; k++)
      check($sformatf("regbank[%0d] identity", k), dut.regbank[k], 16'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd3,  4'd5,  10, ADD,   8'd125, 16'd8};
    vecs[1]  = '{4'd3,  4'd8,  12, MUL,   8'd126, 16'd24};
    vecs[2]  = '{4'd7,  4'd0,  13, SLA,   8'd127, 16'd14};
    vecs[3]  = '{4'd10, 4'd5,  9,  SUB,   8'd128, 16'd3};
    vecs[4]  = '{4'd14, 4'd14, 14, SELA,  8'd255, 16'd14};
    vecs[5]  = '{4'd12, 4'd13, 16, ADD,   8'd130, 16'd38};
    vecs[6]  = '{4'd0,  4'd1,  11, SUB,   8'd140, 16'hFFFF};
    vecs[7]  = '{4'd0,  4'd0,  11, NEGA,  8'd141, 16'hFFFF};
    vecs[8]  = '{4'd7,  4'd0,  11, SRA,   8'd142, 16'd3};
    vecs[9]  = '{4'd3,  4'd5,  11, 4'd13, 8'd143, 16'd0};
    vecs[10] = '{4'd15, 4'd15, 11, MUL,   8'd144, 16'd225};
    vecs[11] = '{4'd12, 4'd13, 11, AND,   8'd145, 16'd8};
    vecs[12] = '{4'd12, 4'd13, 11, OR,    8'd146, 16'd30};
    vecs[13] = '{4'd12, 4'd13, 11, XOR,   8'd147, 16'd22};
    vecs[14] = '{4'd0,  4'd5,  11, NEGB,  8'd148, 16'hFFFA};
    vecs[15] = '{4'd0,  4'd9,  11, SELB,  8'd149, 16'd3};
    vecs[16] = '{4'd14, 4'd14, 14, SELA,  8'd255, 16'd14};

    do_reset(2);

    for (int i = 0; i < 17; i++)
      step(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].func, vecs[i].addr, vecs[i].exp, 1'b1);
    repeat (4) idle();

    // Three instructions in flight when reset hits; none may leave a trace.
    step(4'd2, 4'd0, 1, SELA, 8'd125, 16'd2, 1'b0);
    step(4'd4, 4'd0, 2, SELA, 8'd126, 16'd4, 1'b0);
    step(4'd6, 4'd0, 4, SELA, 8'd127, 16'd6, 1'b0);
    do_reset(1);
    check("mem[125] kept", dut.mem[125], 16'd8);
    check("mem[126] kept", dut.mem[126], 16'd24);
    check("mem[127] kept", dut.mem[127], 16'd14);

    // Consumer one cycle behind sees old r10, three cycles behind sees new.
    step(4'd3,  4'd5, 10, ADD, 8'd131, 16'd8, 1'b1);
    step(4'd10, 4'd5, 9,  SUB, 8'd132, 16'd5, 1'b1);
    idle();
    step(4'd10, 4'd5, 9,  SUB, 8'd133, 16'd3, 1'b1);
    repeat (4) idle();

    check("mem[125] final", dut.mem[125], 16'd8);
    check("mem[126] final", dut.mem[126], 16'd24);
    check("mem[127] final", dut.mem[127], 16'd14);
    check("mem[130] wrap", dut.mem[130], 16'd38);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ex_2.md
# pipe_ex_2

Four-stage register-to-register ALU pipeline with a 16×16 register bank and a 256×16 result memory. Each cycle it accepts one instruction: two source registers, a destination register, an ALU function and a memory address. It reads the operands, computes the result, writes it back to the register bank, then stores it in memory. It is a self-contained datapath demonstrator driven directly by a stimulus source.

## Interface
- `DATA_W`, default 16, operand/result/register/memory word width.
- `ADDR_W`, default 8, memory address width (memory depth 2^ADDR_W).
- `clk`, input, 1 bit: single clock, all state updates on rising edge.
- `rst_n`, input, 1 bit: reset, synchronous and active-low.
- `Z`, output, DATA_W bits: stage-3 result register.
- `rs1`, input, 4 bits: source register A index.
- `rs2`, input, 4 bits: source register B index.
- `rd`, input, 4 bits: destination register index.
- `func`, input, 4 bits: ALU function code.
- `addr`, input, ADDR_W bits: memory write address.

## Operation
- Storage arrays are named `regbank[0:15]` and `mem[0:2^ADDR_W-1]`, so the bench can read and preset them hierarchically.
- Stage 1 (decode/read):
  - Latch A = regbank[rs1], B = regbank[rs2].
  - Latch rd, func, addr and valid bit v12 = 1.
- Stage 2 (execute), all arithmetic modulo 2^DATA_W:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 MUL low DATA_W bits of A×B
  - 3 pass A
  - 4 pass B
  - 5 A&B
  - 6 A|B
  - 7 A^B
  - 8 ~A
  - 9 ~B
  - 10 A>>1 logical
  - 11 A<<1
  - 12–15 result 0
  - Latch result, rd, addr, v23.
- Stage 3 (write-back): if v23, regbank[rd] <= result. Latch Z <= result, addr, v34.
- Stage 4 (store): if v34, mem[addr] <= Z.
- No stalls, no forwarding, no hazard detection. One instruction enters every cycle after reset.
- Reset (rst_n low at a rising edge):
  - Z, all pipeline registers and v12/v23/v34 clear to 0.
  - regbank[k] <= k for k = 0..15.
  - mem is untouched.
  - No regbank or mem write occurs on a reset edge.

## Timing
- Inputs are sampled at edge E0.
- The result is in the stage-2 register after E1.
- regbank[rd] is written, and Z shows the result, after E2 (latency 3 edges).
- mem[addr] is written at E3.
- Z holds its value until the next edge. Z is 0 from reset until the first instruction reaches stage 3.
- Register read sees only writes committed at earlier edges.
  - A consumer issued 3 or more cycles after its producer reads the new value.
  - A consumer issued 1–2 cycles after reads the old value.
- Same-edge write-back and read of the same register: the read returns the old value.
- Reset mid-operation: all in-flight instructions are discarded with no side effects. The first write after release comes from the instruction sampled at the first non-reset edge.
- rd/rs are 4-bit, so index 16 wraps to 0. Same-address mem writes on consecutive cycles: last write wins.

## Structure
- Shared package holds:
  - `DATA_W` and `ADDR_W` defaults.
  - The func code constants (ADD, SUB, MUL, SELA, SELB, AND, OR, XOR, NEGA, NEGB, SRA, SLA).
- One natural sub-module: `pipe_alu`, a combinational function unit taking A, B, func and producing the result.
- Pipeline registers, regbank and mem live in the top.

## Test plan
- Reset, then ADD rs1=3 rs2=5 rd=10 addr=125:
  - Z=8 after third edge.
  - regbank[10]=8.
  - mem[125]=8 after fourth edge.
- Back-to-back, one per cycle:
  - MUL 3,8 rd=12 addr=126 gives 24.
  - func=11 rs1=7 rd=13 addr=127 gives 14.
  - Z shows 24 then 14 on consecutive cycles.
  - mem[126]=24, mem[127]=14.
- Hazard: SUB rs1=10 rs2=5 after ADD 3+5→r10.
  - Issued 3 cycles later gives 3.
  - Issued 1 cycle later gives 5 (old r10=10).
- Wrap: rd=16 (becomes 0), ADD r12(24)+r13(14), addr=130 gives Z=38, regbank[0]=38, mem[130]=38.
- Edge ops:
  - SUB 0−1 gives 0xFFFF.
  - func=8 with A=0 gives 0xFFFF.
  - func=10 with A=7 gives 3.
  - func=13 gives 0.
  - MUL 15×15 gives 225.
- Reset mid-operation:
  - Drop rst_n one cycle with 3 instructions in flight.
  - Z=0 next edge.
  - No regbank/mem writes from flushed instructions.
  - regbank restored to identity.
